// File: rtl/tank_pkg.sv
// Shared types for the tank shell datapath: facing direction, slot owner, slot state.
`timescale 1ns/1ps
package tank_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic {
        TANK0 = 1'b0,
        TANK1 = 1'b1
    } owner_t;

    typedef enum logic {
        SLOT_FREE   = 1'b0,
        SLOT_FLIGHT = 1'b1
    } slot_state_t;

endpackage

// File: rtl/shell_fire_gate.sv
// Per-tank fire gate: key edge detect, pending request, post-grant cooldown, eligibility.
// Latency: eligible is combinational from the key edge; pending/cooldown update on the grant edge.
// Backpressure: a request that is not granted stays pending until the scheduler grants it.
`timescale 1ns/1ps
module shell_fire_gate #(
    parameter int COOLDOWN = 8
) (
    input  logic frame_clk,
    input  logic Reset_n,
    input  logic fire_key,
    input  logic cap_ok,
    input  logic grant_now,
    output logic eligible
);

    localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

    logic          fire_prev;
    logic          pending_q;
    logic          pending_now;
    logic [CW-1:0] cooldown_q;

    assign pending_now = pending_q | (fire_key & ~fire_prev);
    assign eligible    = pending_now && (cooldown_q == '0) && cap_ok;

    // fire_prev resets high so a key held through reset is not seen as a fresh press.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fire_prev  <= 1'b1;
            pending_q  <= 1'b0;
            cooldown_q <= '0;
        end else begin
            fire_prev <= fire_key;
            pending_q <= pending_now & ~grant_now;
            if (grant_now) begin
                cooldown_q <= CW'(COOLDOWN);
            end else if (cooldown_q != '0) begin
                cooldown_q <= cooldown_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/shell_scheduler.sv
// Shares NUM_SLOTS shell datapaths between two tanks with round-robin on a contended slot.
// Latency: key edge sampled in frame N gives registered grant/launch in frame N+1.
// Backpressure: no slot, cap or cooldown keeps the request pending. SHELL_LIFETIME_EN adds forced retire.
`timescale 1ns/1ps
module shell_scheduler
    import tank_pkg::*;
#(
    parameter int NUM_SLOTS    = 4,
    parameter int MAX_PER_TANK = 2,
    parameter int COOLDOWN     = 8
`ifdef SHELL_LIFETIME_EN
    ,
    parameter int MAX_LIFE     = 48
`endif
) (
    input  logic                           frame_clk,
    input  logic                           Reset_n,
    input  logic [1:0]                     fire_req,
    input  logic [1:0]                     tankdir0,
    input  logic [1:0]                     tankdir1,
    input  logic [NUM_SLOTS-1:0]           slot_done,
    output logic [NUM_SLOTS-1:0]           launch_valid,
    output logic [NUM_SLOTS-1:0]           launch_owner,
    output logic [2*NUM_SLOTS-1:0]         launch_dir,
    output logic [NUM_SLOTS-1:0]           slot_busy,
    output logic [1:0]                     grant,
    output logic [$clog2(NUM_SLOTS+1)-1:0] inflight0,
    output logic [$clog2(NUM_SLOTS+1)-1:0] inflight1
);

    localparam int IW = $clog2(NUM_SLOTS + 1);
    localparam int SW = $clog2(NUM_SLOTS);

    slot_state_t          slot_state_q [NUM_SLOTS];
    owner_t               slot_owner_q [NUM_SLOTS];
    logic [IW-1:0]        inflight_q   [2];
    logic [IW-1:0]        inflight_next[2];
    logic                 rr_q;
    logic                 toggle_rr;
    logic [1:0]           eligible;
    logic [1:0]           cap_ok;
    logic [1:0]           grant_now;
    logic [SW-1:0]        alloc_slot   [2];
    logic [SW-1:0]        free_first;
    logic [SW-1:0]        free_second;
    logic                 have_first;
    logic                 have_second;
    logic [NUM_SLOTS-1:0] launch_now;
    logic [NUM_SLOTS-1:0] launch_tank1;
    logic [NUM_SLOTS-1:0] retire;
    logic [NUM_SLOTS-1:0] life_expired;

    for (genvar t = 0; t < 2; t++) begin : g_gate
        assign cap_ok[t] = inflight_q[t] < IW'(MAX_PER_TANK);

        shell_fire_gate #(
            .COOLDOWN (COOLDOWN)
        ) u_gate (
            .frame_clk (frame_clk),
            .Reset_n   (Reset_n),
            .fire_key  (fire_req[t]),
            .cap_ok    (cap_ok[t]),
            .grant_now (grant_now[t]),
            .eligible  (eligible[t])
        );
    end

    always_comb begin
        have_first  = 1'b0;
        have_second = 1'b0;
        free_first  = '0;
        free_second = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (slot_state_q[k] == SLOT_FREE) begin
                if (!have_first) begin
                    have_first = 1'b1;
                    free_first = SW'(k);
                end else if (!have_second) begin
                    have_second = 1'b1;
                    free_second = SW'(k);
                end
            end
        end
    end

    // rr_q only moves when a single free slot was actually fought over.
    always_comb begin
        grant_now     = 2'b00;
        toggle_rr     = 1'b0;
        alloc_slot[0] = free_first;
        alloc_slot[1] = free_first;
        if (eligible == 2'b11) begin
            if (have_second) begin
                grant_now         = 2'b11;
                alloc_slot[rr_q]  = free_first;
                alloc_slot[~rr_q] = free_second;
            end else if (have_first) begin
                grant_now[rr_q] = 1'b1;
                toggle_rr       = 1'b1;
            end
        end else if (eligible[0] && have_first) begin
            grant_now[0] = 1'b1;
        end else if (eligible[1] && have_first) begin
            grant_now[1] = 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
            launch_tank1[k] = grant_now[1] && (alloc_slot[1] == SW'(k));
            launch_now[k]   = (grant_now[0] && (alloc_slot[0] == SW'(k))) || launch_tank1[k];
            retire[k]       = (slot_state_q[k] == SLOT_FLIGHT) && (slot_done[k] || life_expired[k]);
            slot_busy[k]    = (slot_state_q[k] == SLOT_FLIGHT);
        end
    end

    // Several owned slots may retire in one frame, so count them all.
    always_comb begin
        for (int t = 0; t < 2; t++) begin
            inflight_next[t] = inflight_q[t] + IW'(grant_now[t]);
            for (int k = 0; k < NUM_SLOTS; k++) begin
                if (retire[k] && (slot_owner_q[k] == owner_t'(t))) begin
                    inflight_next[t] = inflight_next[t] - IW'(1);
                end
            end
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_q          <= 1'b0;
            grant         <= 2'b00;
            launch_valid  <= '0;
            launch_owner  <= '0;
            launch_dir    <= '0;
            inflight_q[0] <= '0;
            inflight_q[1] <= '0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slot_state_q[k] <= SLOT_FREE;
                slot_owner_q[k] <= TANK0;
            end
        end else begin
            rr_q          <= rr_q ^ toggle_rr;
            grant         <= grant_now;
            inflight_q[0] <= inflight_next[0];
            inflight_q[1] <= inflight_next[1];
            for (int k = 0; k < NUM_SLOTS; k++) begin
                launch_valid[k]      <= launch_now[k];
                launch_owner[k]      <= launch_tank1[k];
                launch_dir[2*k +: 2] <= launch_now[k] ? (launch_tank1[k] ? tankdir1 : tankdir0) : DIR_UP;
                if (launch_now[k]) begin
                    slot_state_q[k] <= SLOT_FLIGHT;
                    slot_owner_q[k] <= launch_tank1[k] ? TANK1 : TANK0;
                end else if (retire[k]) begin
                    slot_state_q[k] <= SLOT_FREE;
                end
            end
        end
    end

`ifdef SHELL_LIFETIME_EN
    localparam int LW = $clog2(MAX_LIFE + 1);

    logic [LW-1:0] life_q [NUM_SLOTS];

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                life_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                if (launch_now[k]) begin
                    life_q[k] <= '0;
                end else if (slot_state_q[k] == SLOT_FLIGHT) begin
                    life_q[k] <= life_q[k] + LW'(1);
                end
            end
        end
    end

    // Expiring on the last count keeps a shell alive for exactly MAX_LIFE frames.
    always_comb begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
            life_expired[k] = (slot_state_q[k] == SLOT_FLIGHT) && (life_q[k] == LW'(MAX_LIFE - 1));
        end
    end
`else
    assign life_expired = '0;
`endif

    assign inflight0 = inflight_q[0];
    assign inflight1 = inflight_q[1];

endmodule
